// File: rtl/theta_episode_replay.sv
// Episode ring buffer with per-window topic vote and valid/ready replay stream.
// Optional build macro REPLAY_REVERSE_EN: replay runs newest->oldest instead of oldest->newest.
module theta_episode_replay #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int TOPIC_LEN = 5,
    parameter int STR_MIN   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          theta_tick,
    input  logic          ep_valid,
    input  logic [2:0]    ep_winner,
    input  logic [3:0]    ep_strength,
    input  logic          explore_mode,
    input  logic          replay_req,
    output logic          replay_valid,
    input  logic          replay_ready,
    output logic [2:0]    replay_winner,
    output logic [3:0]    replay_strength,
    output logic          replay_last,
    output logic          busy,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          delta_tick_out,
    output logic [2:0]    topic_winner,
    output logic [2:0]    topic_strength,
    output logic          topic_valid
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [2:0]  LAST_TH   = 3'(TOPIC_LEN - 1);
    localparam logic [2:0]  VALID_MIN = 3'((TOPIC_LEN + 1) / 2);
    localparam logic [3:0]  STR_THR   = 4'(STR_MIN);

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        STREAM
    } state_t;

    state_t state, state_next;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   snap_n;
    logic [AW:0]   beat;
    logic [2:0]    th_cnt;
    logic [2:0]    vote     [8];
    logic [2:0]    vote_eff [8];
    logic [2:0]    best_idx;
    logic [2:0]    best_cnt;
    logic          capture;
    logic          full;
    logic          write_en;

    // A full buffer may only be overwritten while no snapshot is being replayed.
    always_comb begin
        capture  = theta_tick && ep_valid && !explore_mode && (ep_strength >= STR_THR);
        full     = (count == FULL_CNT);
        write_en = capture && (!full || (state == IDLE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_base  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= capture && full;
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    rd_base <= rd_base + 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            mem[wr_ptr] <= {ep_winner, ep_strength};
        end
    end

    always_comb begin
        state_next      = state;
        busy            = (state != IDLE);
        replay_valid    = 1'b0;
        replay_last     = 1'b0;
        replay_winner   = 3'd0;
        replay_strength = 4'd0;
        case (state)
            IDLE: begin
                if (replay_req && (count != '0)) begin
                    state_next = SNAP;
                end
            end
            SNAP: begin
                state_next = STREAM;
            end
            STREAM: begin
                replay_valid                     = 1'b1;
                replay_last                      = (beat == snap_n - 1'b1);
                {replay_winner, replay_strength} = mem[rd_ptr];
                if (replay_ready && replay_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Snapshot length and start point are frozen in SNAP so later captures never join this replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            snap_n <= '0;
            beat   <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == SNAP) begin
                snap_n <= count;
                beat   <= '0;
`ifdef REPLAY_REVERSE_EN
                rd_ptr <= rd_base + AW'(count - 1'b1);
`else
                rd_ptr <= rd_base;
`endif
            end else if ((state == STREAM) && replay_ready) begin
                beat <= beat + 1'b1;
`ifdef REPLAY_REVERSE_EN
                rd_ptr <= rd_ptr - 1'b1;
`else
                rd_ptr <= rd_ptr + 1'b1;
`endif
            end
        end
    end

    // Votes including the current tick; strict compare keeps the lowest index on ties.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            vote_eff[i] = vote[i] + {2'b00, (ep_valid && (ep_winner == 3'(i)))};
        end
        best_idx = 3'd0;
        best_cnt = vote_eff[0];
        for (int i = 1; i < 8; i++) begin
            if (vote_eff[i] > best_cnt) begin
                best_cnt = vote_eff[i];
                best_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            th_cnt         <= '0;
            delta_tick_out <= 1'b0;
            topic_winner   <= '0;
            topic_strength <= '0;
            topic_valid    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                vote[i] <= '0;
            end
        end else begin
            delta_tick_out <= 1'b0;
            if (theta_tick) begin
                if (th_cnt == LAST_TH) begin
                    th_cnt         <= '0;
                    delta_tick_out <= 1'b1;
                    topic_winner   <= best_idx;
                    topic_strength <= best_cnt;
                    topic_valid    <= (best_cnt >= VALID_MIN);
                    for (int i = 0; i < 8; i++) begin
                        vote[i] <= '0;
                    end
                end else begin
                    th_cnt <= th_cnt + 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        vote[i] <= vote_eff[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_theta_episode_replay.sv
// Self-checking bench for theta_episode_replay: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model of buffer, replay stream and topic vote.
module tb_theta_episode_replay;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int TOPIC_LEN = 5;
    localparam int STR_MIN   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          theta_tick = 1'b0;
    logic          ep_valid = 1'b0;
    logic [2:0]    ep_winner = '0;
    logic [3:0]    ep_strength = '0;
    logic          explore_mode = 1'b0;
    logic          replay_req = 1'b0;
    logic          replay_valid;
    logic          replay_ready = 1'b0;
    logic [2:0]    replay_winner;
    logic [3:0]    replay_strength;
    logic          replay_last;
    logic          busy;
    logic [AW:0]   count;
    logic          overflow;
    logic          delta_tick_out;
    logic [2:0]    topic_winner;
    logic [2:0]    topic_strength;
    logic          topic_valid;

    always #5 clk = ~clk;

    theta_episode_replay #(
        .DEPTH(DEPTH), .AW(AW), .TOPIC_LEN(TOPIC_LEN), .STR_MIN(STR_MIN)
    ) dut (
        .clk(clk), .rst(rst), .theta_tick(theta_tick), .ep_valid(ep_valid),
        .ep_winner(ep_winner), .ep_strength(ep_strength), .explore_mode(explore_mode),
        .replay_req(replay_req), .replay_valid(replay_valid), .replay_ready(replay_ready),
        .replay_winner(replay_winner), .replay_strength(replay_strength),
        .replay_last(replay_last), .busy(busy), .count(count), .overflow(overflow),
        .delta_tick_out(delta_tick_out), .topic_winner(topic_winner),
        .topic_strength(topic_strength), .topic_valid(topic_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stored episodes oldest-first, pending beats, topic window history.
    logic [6:0] m_buf[$];
    logic [6:0] m_beats[$];
    logic [2:0] m_hist[$];
    bit         m_snap;
    bit         m_ovf;
    bit         m_delta;
    int         m_th;
    int         m_tw;
    int         m_ts;
    bit         m_tv;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit         pre_busy;
        logic [6:0] snap[$];
        int         cnt[8];
        if (rst) begin
            m_buf.delete(); m_beats.delete(); m_hist.delete();
            m_snap = 0; m_ovf = 0; m_delta = 0; m_th = 0;
            m_tw = 0; m_ts = 0; m_tv = 0;
            return;
        end
        pre_busy = m_snap || (m_beats.size() > 0);
        snap = m_buf;
        if ((m_beats.size() > 0) && replay_ready) void'(m_beats.pop_front());
        if (m_snap) begin
            m_beats.delete();
`ifdef REPLAY_REVERSE_EN
            for (int i = snap.size() - 1; i >= 0; i--) m_beats.push_back(snap[i]);
`else
            foreach (snap[i]) m_beats.push_back(snap[i]);
`endif
            m_snap = 0;
        end else if (!pre_busy && replay_req && (m_buf.size() > 0)) begin
            m_snap = 1;
        end
        m_ovf = 0;
        if (theta_tick && ep_valid && !explore_mode && (int'(ep_strength) >= STR_MIN)) begin
            if (m_buf.size() < DEPTH) begin
                m_buf.push_back({ep_winner, ep_strength});
            end else begin
                m_ovf = 1;
                if (!pre_busy) begin
                    void'(m_buf.pop_front());
                    m_buf.push_back({ep_winner, ep_strength});
                end
            end
        end
        m_delta = 0;
        if (theta_tick) begin
            if (ep_valid) m_hist.push_back(ep_winner);
            m_th++;
            if (m_th == TOPIC_LEN) begin
                for (int i = 0; i < 8; i++) cnt[i] = 0;
                foreach (m_hist[i]) cnt[m_hist[i]]++;
                m_tw = 0;
                for (int i = 1; i < 8; i++) if (cnt[i] > cnt[m_tw]) m_tw = i;
                m_ts = cnt[m_tw];
                m_tv = (m_ts >= (TOPIC_LEN + 1) / 2);
                m_delta = 1;
                m_th = 0;
                m_hist.delete();
            end
        end
    endtask

    task automatic check_model();
        bit streaming;
        streaming = (m_beats.size() > 0);
        checkOutput("count", 8'(count), 8'(m_buf.size()));
        checkOutput("busy", 8'(busy), 8'(m_snap || streaming));
        checkOutput("replay_valid", 8'(replay_valid), 8'(streaming));
        if (streaming) begin
            checkOutput("replay_winner", 8'(replay_winner), 8'(m_beats[0][6:4]));
            checkOutput("replay_strength", 8'(replay_strength), 8'(m_beats[0][3:0]));
            checkOutput("replay_last", 8'(replay_last), 8'(m_beats.size() == 1));
        end
        checkOutput("overflow", 8'(overflow), 8'(m_ovf));
        checkOutput("delta_tick_out", 8'(delta_tick_out), 8'(m_delta));
        checkOutput("topic_winner", 8'(topic_winner), 8'(m_tw));
        checkOutput("topic_strength", 8'(topic_strength), 8'(m_ts));
        checkOutput("topic_valid", 8'(topic_valid), 8'(m_tv));
    endtask

    task automatic applyStimulus(input bit rs, input bit tick, input bit ev, input logic [2:0] w,
                                 input logic [3:0] s, input bit expl, input bit req, input bit rdy);
        rst = rs; theta_tick = tick; ep_valid = ev; ep_winner = w; ep_strength = s;
        explore_mode = expl; replay_req = req; replay_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 0, rdy);
    endtask

    task automatic cap(input logic [2:0] w, input logic [3:0] s);
        applyStimulus(0, 1, 1, w, s, 0, 0, 1);
    endtask

    initial begin
        int exp_s1[3];
        int exp_s3[10];
        int held;
        int got[$];
        int ovf_seen;
`ifdef REPLAY_REVERSE_EN
        exp_s1 = '{4, 2, 0};
        exp_s3 = '{1, 0, 7, 6, 5, 4, 3, 2, 0, 0};
        held = 5;
`else
        exp_s1 = '{0, 2, 4};
        exp_s3 = '{2, 3, 4, 5, 6, 7, 0, 1, 0, 0};
        held = 2;
`endif
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        checkOutput("reset_count", 8'(count), 8'd0);
        checkOutput("reset_busy", 8'(busy), 8'd0);

        // Three strong episodes, then a replay with two-cycle latency.
        cap(3'd0, 4'd8); idle(1, 1); cap(3'd2, 4'd8); idle(1, 1); cap(3'd4, 4'd8);
        checkOutput("s1_count", 8'(count), 8'd3);
        applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 1);
        checkOutput("s1_snap_no_valid", 8'(replay_valid), 8'd0);
        for (int b = 0; b < 3; b++) begin
            idle(1, 1);
            checkOutput("s1_beat_valid", 8'(replay_valid), 8'd1);
            checkOutput("s1_beat_winner", 8'(replay_winner), 8'(exp_s1[b]));
            checkOutput("s1_beat_last", 8'(replay_last), 8'(b == 2));
        end
        idle(1, 1);
        checkOutput("s1_done", 8'(replay_valid), 8'd0);

        // Weak and exploratory episodes are not stored.
        cap(3'd1, 4'd5);
        applyStimulus(0, 1, 1, 3'd1, 4'd8, 1, 0, 1);
        idle(1, 1);
        checkOutput("s2_count", 8'(count), 8'd3);

        // Ten captures into an idle 8-deep buffer overwrite the oldest two.
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        ovf_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cap(3'(i), 4'd7);
            ovf_seen += int'(overflow);
        end
        idle(1, 1);
        checkOutput("s3_count", 8'(count), 8'd8);
        checkOutput("s3_ovf_pulses", 8'(ovf_seen), 8'd2);
        applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 1);
        got.delete();
        for (int i = 0; i < 12; i++) begin
            idle(1, 1);
            if (replay_valid) got.push_back(int'(replay_winner));
        end
        checkOutput("s3_beats", 8'(got.size()), 8'd8);
        for (int i = 0; i < 8; i++) checkOutput("s3_order", 8'(got[i]), 8'(exp_s3[i]));

        // Topic windows: clear majority, then an all-distinct window.
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        applyStimulus(0, 1, 1, 3'd1, 4'd2, 0, 0, 1);
        applyStimulus(0, 1, 1, 3'd1, 4'd2, 0, 0, 1);
        applyStimulus(0, 1, 1, 3'd2, 4'd2, 0, 0, 1);
        applyStimulus(0, 1, 1, 3'd1, 4'd2, 0, 0, 1);
        applyStimulus(0, 1, 1, 3'd3, 4'd2, 0, 0, 1);
        checkOutput("s4_delta", 8'(delta_tick_out), 8'd1);
        checkOutput("s4_winner", 8'(topic_winner), 8'd1);
        checkOutput("s4_strength", 8'(topic_strength), 8'd3);
        checkOutput("s4_valid", 8'(topic_valid), 8'd1);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 1, 3'(i), 4'd2, 0, 0, 1);
        checkOutput("s4b_winner", 8'(topic_winner), 8'd1);
        checkOutput("s4b_strength", 8'(topic_strength), 8'd1);
        checkOutput("s4b_valid", 8'(topic_valid), 8'd0);
        idle(1, 1);
        checkOutput("s4b_delta_pulse", 8'(delta_tick_out), 8'd0);

        // Backpressure mid-stream with a full-buffer capture dropped while busy.
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cap(3'(i), 4'd8);
        applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 1);
        idle(3, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) applyStimulus(0, 1, 1, 3'd7, 4'd8, 0, 0, 0);
            else idle(1, 0);
            checkOutput("s5_held_winner", 8'(replay_winner), 8'(held));
            checkOutput("s5_held_valid", 8'(replay_valid), 8'd1);
        end
        idle(10, 1);
        checkOutput("s5_count", 8'(count), 8'd8);
        checkOutput("s5_idle", 8'(busy), 8'd0);

        // Reset in the middle of a stream, then a request against an empty buffer.
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        cap(3'd1, 4'd8); cap(3'd2, 4'd8); cap(3'd3, 4'd8);
        applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);
        idle(2, 0);
        applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
        checkOutput("s6_valid", 8'(replay_valid), 8'd0);
        checkOutput("s6_busy", 8'(busy), 8'd0);
        checkOutput("s6_count", 8'(count), 8'd0);
        applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 1);
        idle(2, 1);
        checkOutput("s6_req_ignored", 8'(busy), 8'd0);
        checkOutput("s6_no_beats", 8'(replay_valid), 8'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 8)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
